// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package restoring_divider_pkg;

    // Operand and result width (divisor, quotient, remainder).
    localparam int DIV_W = 8;

    // One quotient bit is resolved per SHIFT/SUB pair.
    localparam int DIV_ITER = 8;

    // Cycles from the edge that samples enable to the first cycle with done=1.
    localparam int DIV_LATENCY     = 23;
    localparam int DIV_OVF_LATENCY = 5;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD_M = 4'd1,
        LOAD_A = 4'd2,
        LOAD_Q = 4'd3,
        CHECK  = 4'd4,
        SHIFT  = 4'd5,
        SUB    = 4'd6,
        OUT_R  = 4'd7,
        OUT_Q  = 4'd8,
        DONE   = 4'd9
    } div_state_t;

endpackage

// File: rtl/restoring_divider_if.sv
// Handshake and multiplexed operand/result buses of the divider.
interface div_if;
    import restoring_divider_pkg::*;

    logic             enable;
    logic [DIV_W-1:0] inbus;
    logic             done;
    logic             ovf;
    logic [DIV_W-1:0] outbus;

    // The requester drives operands and the start request.
    modport master (
        output enable,
        output inbus,
        input  done,
        input  ovf,
        input  outbus
    );

    // The divider consumes operands and returns results.
    modport slave (
        input  enable,
        input  inbus,
        output done,
        output ovf,
        output outbus
    );

endinterface

// File: rtl/counter_3bits.sv
// 3-bit up counter with synchronous clear; wraps 7 -> 0.
module counter_3bits (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [2:0] cnt_o
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 3'd0;
        end else if (inc_i) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/restoring_divider_cu.sv
// Control unit of the divider: next-state decode and datapath enables.
module div_cu
    import restoring_divider_pkg::*;
(
    input  div_state_t state_i,
    input  logic       enable_i,
    input  logic       a_ge_m_i,
    input  logic       cnt_last_i,
    input  logic       sub_neg_i,
    output div_state_t state_d_o,
    output logic       ld_m_o,
    output logic       ld_a_o,
    output logic       ld_q_o,
    output logic       shift_o,
    output logic       sub_wr_o,
    output logic       q_wr_o,
    output logic       q_bit_o,
    output logic       cnt_clr_o,
    output logic       cnt_inc_o,
    output logic       ovf_set_o,
    output logic       ovf_clr_o,
    output logic       sel_r_o,
    output logic       sel_q_o,
    output logic       done_o
);

    // Next state and one-cycle enables, all defaulted to idle behaviour.
    always_comb begin
        state_d_o = state_i;
        ld_m_o    = 1'b0;
        ld_a_o    = 1'b0;
        ld_q_o    = 1'b0;
        shift_o   = 1'b0;
        sub_wr_o  = 1'b0;
        q_wr_o    = 1'b0;
        q_bit_o   = 1'b0;
        cnt_clr_o = 1'b0;
        cnt_inc_o = 1'b0;
        ovf_set_o = 1'b0;
        ovf_clr_o = 1'b0;
        sel_r_o   = 1'b0;
        sel_q_o   = 1'b0;
        done_o    = 1'b0;
        case (state_i)
            IDLE: begin
                if (enable_i) state_d_o = LOAD_M;
            end
            LOAD_M: begin
                ld_m_o    = 1'b1;
                ovf_clr_o = 1'b1;
                cnt_clr_o = 1'b1;
                state_d_o = LOAD_A;
            end
            LOAD_A: begin
                ld_a_o    = 1'b1;
                state_d_o = LOAD_Q;
            end
            LOAD_Q: begin
                ld_q_o    = 1'b1;
                state_d_o = CHECK;
            end
            CHECK: begin
                // A high byte not below the divisor means the quotient
                // cannot fit 8 bits; this also catches a zero divisor.
                if (a_ge_m_i) begin
                    ovf_set_o = 1'b1;
                    state_d_o = DONE;
                end else begin
                    state_d_o = SHIFT;
                end
            end
            SHIFT: begin
                shift_o   = 1'b1;
                state_d_o = SUB;
            end
            SUB: begin
                sub_wr_o  = !sub_neg_i;
                q_wr_o    = 1'b1;
                q_bit_o   = !sub_neg_i;
                cnt_inc_o = 1'b1;
                state_d_o = cnt_last_i ? OUT_R : SHIFT;
            end
            OUT_R: begin
                sel_r_o   = 1'b1;
                state_d_o = OUT_Q;
            end
            OUT_Q: begin
                sel_q_o   = 1'b1;
                state_d_o = DONE;
            end
            DONE: begin
                done_o = 1'b1;
                if (!enable_i) state_d_o = IDLE;
            end
            default: begin
                state_d_o = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: 16-bit dividend / 8-bit divisor,
// operands in over a multiplexed byte bus, remainder then quotient out.
module restoring_divider
    import restoring_divider_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    div_if.slave bus
);

    div_state_t       state_q;
    div_state_t       state_d;

    logic [DIV_W-1:0] m_q;
    logic [DIV_W-1:0] a_q;
    logic [DIV_W-1:0] q_q;
    logic             f_q;
    logic             ovf_q;

    logic [2:0]       cnt;
    logic             cnt_last;
    logic             a_ge_m;

    logic             sub_borrow;
    logic [DIV_W:0]   sub_d;
    logic             sub_neg;

    logic ld_m, ld_a, ld_q, shift_en, sub_wr, q_wr, q_bit;
    logic cnt_clr, cnt_inc, ovf_set, ovf_clr, sel_r, sel_q, done_w;

    assign cnt_last = (cnt == 3'(DIV_ITER - 1));
    assign a_ge_m   = (a_q >= m_q);

    // 9-bit trial subtraction {F,A} - M with an extra borrow bit. When no
    // borrow occurs the difference is below M, so bit 8 can only be set
    // alongside a borrow; either one marks the trial as negative.
    assign {sub_borrow, sub_d} = {1'b0, f_q, a_q} - {2'b00, m_q};
    assign sub_neg = sub_borrow | sub_d[DIV_W];

    div_cu u_cu (
        .state_i    (state_q),
        .enable_i   (bus.enable),
        .a_ge_m_i   (a_ge_m),
        .cnt_last_i (cnt_last),
        .sub_neg_i  (sub_neg),
        .state_d_o  (state_d),
        .ld_m_o     (ld_m),
        .ld_a_o     (ld_a),
        .ld_q_o     (ld_q),
        .shift_o    (shift_en),
        .sub_wr_o   (sub_wr),
        .q_wr_o     (q_wr),
        .q_bit_o    (q_bit),
        .cnt_clr_o  (cnt_clr),
        .cnt_inc_o  (cnt_inc),
        .ovf_set_o  (ovf_set),
        .ovf_clr_o  (ovf_clr),
        .sel_r_o    (sel_r),
        .sel_q_o    (sel_q),
        .done_o     (done_w)
    );

    counter_3bits u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .cnt_o (cnt)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: operand loads, 17-bit shift, conditional restore.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q   <= '0;
            a_q   <= '0;
            q_q   <= '0;
            f_q   <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (ld_m) m_q <= bus.inbus;

            if (ld_a) begin
                a_q <= bus.inbus;
            end else if (shift_en) begin
                a_q <= {a_q[DIV_W-2:0], q_q[DIV_W-1]};
            end else if (sub_wr) begin
                a_q <= sub_d[DIV_W-1:0];
            end

            if (ld_q) begin
                q_q <= bus.inbus;
            end else if (shift_en) begin
                q_q <= {q_q[DIV_W-2:0], 1'b0};
            end else if (q_wr) begin
                q_q[0] <= q_bit;
            end

            if (shift_en) f_q <= a_q[DIV_W-1];

            if (ovf_clr) begin
                ovf_q <= 1'b0;
            end else if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.done   = done_w;
    assign bus.ovf    = ovf_q;
    assign bus.outbus = sel_r ? a_q : (sel_q ? q_q : '0);

endmodule

// File: doc/restoring_divider.md
# restoring_divider

Sequential unsigned restoring divider, the inverse companion of the team's shift-add multiplier. It divides a 16-bit dividend by an 8-bit divisor and returns an 8-bit quotient and an 8-bit remainder. Operands enter over the same 8-bit multiplexed `inbus` protocol, and results leave over the same `outbus` protocol. It sits beside the multiplier in the arithmetic unit and uses the same `enable`/`done` handshake.

## Interface
- No parameters. Width is fixed: 8-bit divisor, quotient and remainder; 16-bit dividend.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  start request, sampled only in IDLE and DONE.
- `inbus`  in  8  operand bus: divisor, then dividend high byte, then dividend low byte.
- `done`  out  1  high while in DONE; reset value 0.
- `ovf`  out  1  division overflow or divide-by-zero; valid while `done`=1; reset value 0.
- `outbus`  out  8  remainder in cycle OUT_R, quotient in cycle OUT_Q, 8'h00 in every other cycle; reset value 8'h00. Driven, never Z.

## Operation
- Registers:
  - M (8): divisor.
  - A (8): partial remainder, loaded with the dividend high byte.
  - Q (8): dividend low byte, becomes the quotient.
  - F (1): carry-out of A during shift.
  - CNT (3): iteration counter.
- FSM states: IDLE, LOAD_M, LOAD_A, LOAD_Q, CHECK, SHIFT, SUB, OUT_R, OUT_Q, DONE.
- IDLE: if `enable`=1 → LOAD_M.
- LOAD_M: M←inbus; clear `ovf`; CNT←0 → LOAD_A.
- LOAD_A: A←inbus → LOAD_Q.
- LOAD_Q: Q←inbus → CHECK.
- CHECK: if A ≥ M (unsigned; this covers M=0) then `ovf`←1 → DONE. Otherwise → SHIFT.
- SHIFT: {F,A,Q} ← {A,Q,1'b0}, a 17-bit left shift → SUB.
- SUB: compute the 9-bit difference D = {F,A} − {1'b0,M}.
  - If D ≥ 0: A←D[7:0], Q[0]←1.
  - Otherwise: A unchanged, Q[0]←0.
  - CNT←CNT+1 (wraps 7→0).
  - If CNT was 7 → OUT_R, else → SHIFT.
- OUT_R: outbus=A → OUT_Q.
- OUT_Q: outbus=Q → DONE.
- DONE: `done`=1.
  - `enable`=0 → IDLE.
  - `enable`=1 → stay in DONE. A new operation requires `enable` to drop first.
- `enable` is ignored in every state except IDLE and DONE.
- `rst_n`=0 at any time, including mid-operation: all registers, outputs and the FSM clear to 0/IDLE immediately. No partial result is emitted.

## Timing
- Edge 0: `enable` sampled high in IDLE.
- inbus is captured at edge 1 (divisor), edge 2 (dividend high) and edge 3 (dividend low).
- Cycle 4: CHECK.
- Cycles 5–20: 8 SHIFT/SUB pairs, 2 cycles per quotient bit.
- Cycle 21: outbus = remainder.
- Cycle 22: outbus = quotient.
- Cycle 23 onward: `done`=1.
- Total latency from the `enable` edge to `done` is 23 cycles.
- Overflow path: `done` and `ovf` go high in cycle 5. No OUT_R/OUT_Q cycles occur, and outbus stays 8'h00.
- `ovf` holds its value through DONE and IDLE. It is cleared only in LOAD_M.

## Structure
- Package `restoring_divider_pkg` holds:
  - state enum `div_state_t`;
  - constants `DIV_W=8` and `DIV_ITER=8`;
  - cycle-count constants used by the bench (`DIV_LATENCY=23`, `DIV_OVF_LATENCY=5`).
- Sub-module `div_cu` is the control unit. It takes state, the CNT terminal flag and the subtract sign. It drives the load, shift and write-back enables and the output selects, mirroring the multiplier's `cu`.
- The datapath stays in the top module: M/A/Q/F registers, 9-bit subtractor, output mux.
- The codebase `counter_3bits` is reused for CNT.

## Test plan
- M=7, dividend 16'h03E8 (1000) → cycle 21 outbus=8'h06; cycle 22 outbus=8'h8E (142); `done`=1 from cycle 23; `ovf`=0.
- M=8'hFF, dividend 16'hFE01 → remainder 8'h00, quotient 8'hFF; `ovf`=0.
- M=10, dividend 16'h0005 → remainder 8'h05, quotient 8'h00.
- M=0, any dividend; and M=8'h03, dividend 16'h0300 → `ovf`=1 and `done`=1 in cycle 5; outbus=8'h00 throughout.
- Assert `rst_n`=0 in cycle 12 of an operation → `done`, `ovf` and outbus read 0 asynchronously. After release, a fresh 1000/7 run yields 6/142 with exact timing.
- Hold `enable`=1 in DONE → no restart. Drop `enable` for 1 cycle, then raise it → a second operation runs, and `ovf` from a prior overflow clears in LOAD_M.
